// File: rtl/mem_responder_if.sv
// Request/response bundle between the control unit and the SRAM-side responder.
// slave = responder view; master = control unit plus SRAM view.
interface mem_responder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              MemR1;
  logic              MemR2;
  logic              MemW1;
  logic              MemW2;
  logic [ADDR_W-1:0] addr1;
  logic [ADDR_W-1:0] addr2;
  logic [DATA_W-1:0] wdata1;
  logic [DATA_W-1:0] wdata2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic              ready;
  logic              busy;
  logic              conflict;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic              sram_re;
  logic              sram_we;
  logic [DATA_W-1:0] sram_rdata;

  modport slave (
    input  MemR1, MemR2, MemW1, MemW2, addr1, addr2, wdata1, wdata2, sram_rdata,
    output rdata1, rdata2, ready, busy, conflict, sram_addr, sram_wdata, sram_re, sram_we
  );

  modport master (
    output MemR1, MemR2, MemW1, MemW2, addr1, addr2, wdata1, wdata2, sram_rdata,
    input  rdata1, rdata2, ready, busy, conflict, sram_addr, sram_wdata, sram_re, sram_we
  );
endinterface

// File: rtl/mem_responder.sv
// Serializes two captured memory requests (port 1 first) onto one fixed-latency SRAM.
// Strobes are sampled only in IDLE; completion is a one-cycle ready pulse in DONE.
module mem_responder #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int READ_LAT = 1
) (
  input  logic           clk,
  input  logic           Reset,
  mem_responder_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACC1  = 3'd1,
    WAIT1 = 3'd2,
    ACC2  = 3'd3,
    WAIT2 = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [2:0] LAT_M1 = 3'(READ_LAT - 1);

  state_t            r_state;
  state_t            w_next;
  logic              r_r1, r_w1, r_r2, r_w2;
  logic [ADDR_W-1:0] r_addr1, r_addr2;
  logic [DATA_W-1:0] r_wdata1, r_wdata2;
  logic              r_conflict;
  logic [2:0]        r_cnt;
  logic [DATA_W-1:0] r_rdata1, r_rdata2;

  logic              w_op1_in, w_op2_in, w_op2;
  logic              w_cnt_zero;
  logic [ADDR_W-1:0] w_sram_addr;
  logic [DATA_W-1:0] w_sram_wdata;
  logic              w_sram_re, w_sram_we;

  assign w_op1_in   = bus.MemR1 | bus.MemW1;
  assign w_op2_in   = bus.MemR2 | bus.MemW2;
  assign w_op2      = r_r2 | r_w2;
  assign w_cnt_zero = (r_cnt == 3'd0);

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_op1_in)      w_next = ACC1;
        else if (w_op2_in) w_next = ACC2;
      end
      ACC1:    w_next = r_w1 ? (w_op2 ? ACC2 : DONE) : WAIT1;
      WAIT1:   if (w_cnt_zero) w_next = w_op2 ? ACC2 : DONE;
      ACC2:    w_next = r_w2 ? DONE : WAIT2;
      WAIT2:   if (w_cnt_zero) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_sram_addr  = '0;
    w_sram_wdata = '0;
    w_sram_re    = 1'b0;
    w_sram_we    = 1'b0;
    case (r_state)
      ACC1: begin
        w_sram_addr = r_addr1;
        if (r_w1) begin
          w_sram_we    = 1'b1;
          w_sram_wdata = r_wdata1;
        end else begin
          w_sram_re = 1'b1;
        end
      end
      ACC2: begin
        w_sram_addr = r_addr2;
        if (r_w2) begin
          w_sram_we    = 1'b1;
          w_sram_wdata = r_wdata2;
        end else begin
          w_sram_re = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Write wins over read on the same port, so the captured read flag is masked.
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_r1       <= 1'b0;
      r_w1       <= 1'b0;
      r_r2       <= 1'b0;
      r_w2       <= 1'b0;
      r_addr1    <= '0;
      r_addr2    <= '0;
      r_wdata1   <= '0;
      r_wdata2   <= '0;
      r_conflict <= 1'b0;
    end else if (r_state == IDLE && (w_op1_in || w_op2_in)) begin
      r_r1       <= bus.MemR1 & ~bus.MemW1;
      r_w1       <= bus.MemW1;
      r_r2       <= bus.MemR2 & ~bus.MemW2;
      r_w2       <= bus.MemW2;
      r_addr1    <= bus.addr1;
      r_addr2    <= bus.addr2;
      r_wdata1   <= bus.wdata1;
      r_wdata2   <= bus.wdata2;
      r_conflict <= (bus.MemR1 & bus.MemW1) | (bus.MemR2 & bus.MemW2);
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_cnt    <= 3'd0;
      r_rdata1 <= '0;
      r_rdata2 <= '0;
    end else begin
      case (r_state)
        ACC1, ACC2: r_cnt <= LAT_M1;
        WAIT1, WAIT2: begin
          if (!w_cnt_zero) r_cnt <= r_cnt - 3'd1;
        end
        default: r_cnt <= 3'd0;
      endcase
      if (r_state == WAIT1 && w_cnt_zero) r_rdata1 <= bus.sram_rdata;
      if (r_state == WAIT2 && w_cnt_zero) r_rdata2 <= bus.sram_rdata;
    end
  end

  assign bus.sram_addr  = w_sram_addr;
  assign bus.sram_wdata = w_sram_wdata;
  assign bus.sram_re    = w_sram_re;
  assign bus.sram_we    = w_sram_we;
  assign bus.rdata1     = r_rdata1;
  assign bus.rdata2     = r_rdata2;
  assign bus.ready      = (r_state == DONE);
  assign bus.conflict   = (r_state == DONE) & r_conflict;
  assign bus.busy       = (r_state != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: RL=1 responder driven from a vector table, RL=3 responder for busy-strobe cases.
module tb_mem_responder;
  logic clk = 1'b0;
  logic Reset = 1'b1;
  always #5 clk = ~clk;

  mem_responder_if #(.DATA_W(16), .ADDR_W(16)) ifa ();
  mem_responder_if #(.DATA_W(16), .ADDR_W(16)) ifb ();

  mem_responder #(.DATA_W(16), .ADDR_W(16), .READ_LAT(1)) dut_a (.clk(clk), .Reset(Reset), .bus(ifa));
  mem_responder #(.DATA_W(16), .ADDR_W(16), .READ_LAT(3)) dut_b (.clk(clk), .Reset(Reset), .bus(ifb));

  // SRAM models; unenabled reads return a marker so latency errors surface.
  logic [15:0] mem_a [0:65535];
  logic [15:0] mem_b [0:65535];
  logic [15:0] pa;
  logic [15:0] pb0, pb1, pb2;
  always @(posedge clk) begin
    if (ifa.sram_we) mem_a[ifa.sram_addr] <= ifa.sram_wdata;
    pa <= ifa.sram_re ? mem_a[ifa.sram_addr] : 16'hDEAD;
    if (ifb.sram_we) mem_b[ifb.sram_addr] <= ifb.sram_wdata;
    pb0 <= ifb.sram_re ? mem_b[ifb.sram_addr] : 16'hDEAD;
    pb1 <= pb0;
    pb2 <= pb1;
  end
  assign ifa.sram_rdata = pa;
  assign ifb.sram_rdata = pb2;

  typedef struct {
    logic        r1, r2, w1, w2;
    logic [15:0] a1, a2, d1, d2;
    int          n, we;
    logic [15:0] rd1, rd2;
    logic        conf;
    logic [15:0] maddr, mval;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r1, r2, w1, w2, input logic [15:0] a1, a2, d1, d2,
                              input int n, we, input logic [15:0] rd1, rd2, input logic conf,
                              input logic [15:0] maddr, mval);
    vec_t v;
    v.r1 = r1; v.r2 = r2; v.w1 = w1; v.w2 = w2;
    v.a1 = a1; v.a2 = a2; v.d1 = d1; v.d2 = d2;
    v.n = n; v.we = we; v.rd1 = rd1; v.rd2 = rd2; v.conf = conf;
    v.maddr = maddr; v.mval = mval;
    return v;
  endfunction

  // Called at a negedge with dut_a idle; returns at the negedge of the ready cycle.
  task automatic run_a(input vec_t v, output int n, output int we_cnt,
                       output bit busy_bad, output logic conf);
    ifa.MemR1 = v.r1; ifa.MemR2 = v.r2; ifa.MemW1 = v.w1; ifa.MemW2 = v.w2;
    ifa.addr1 = v.a1; ifa.addr2 = v.a2; ifa.wdata1 = v.d1; ifa.wdata2 = v.d2;
    @(posedge clk);
    @(negedge clk);
    ifa.MemR1 = 0; ifa.MemR2 = 0; ifa.MemW1 = 0; ifa.MemW2 = 0;
    n = 0; we_cnt = 0; busy_bad = 0; conf = 0;
    for (int c = 1; c <= 40; c++) begin
      if (ifa.sram_we) we_cnt++;
      if (!ifa.busy) busy_bad = 1;
      if (ifa.ready) begin
        n = c;
        conf = ifa.conflict;
        break;
      end
      @(negedge clk);
    end
  endtask

  vec_t vecs [8];

  initial begin
    int n, we_cnt, t1, t2;
    bit busy_bad;
    logic conf;
    logic [15:0] rd1_b, rd2_b;

    ifa.MemR1 = 0; ifa.MemR2 = 0; ifa.MemW1 = 0; ifa.MemW2 = 0;
    ifa.addr1 = 0; ifa.addr2 = 0; ifa.wdata1 = 0; ifa.wdata2 = 0;
    ifb.MemR1 = 0; ifb.MemR2 = 0; ifb.MemW1 = 0; ifb.MemW2 = 0;
    ifb.addr1 = 0; ifb.addr2 = 0; ifb.wdata1 = 0; ifb.wdata2 = 0;
    mem_a[16'h0010] = 16'hA5A5;
    mem_a[16'h0011] = 16'h1234;
    mem_a[16'h0030] = 16'h1111;
    mem_a[16'h0070] = 16'h3C3C;
    mem_b[16'h0010] = 16'hCAFE;
    mem_b[16'h0011] = 16'h7777;

    //            r1 r2 w1 w2  a1        a2        d1        d2        n we rd1       rd2       cf maddr     mval
    vecs[0] = mk(1, 1, 0, 0, 16'h0010, 16'h0011, 16'h0000, 16'h0000, 5, 0, 16'hA5A5, 16'h1234, 0, 16'h0010, 16'hA5A5);
    vecs[1] = mk(0, 0, 0, 1, 16'h0000, 16'h0020, 16'h0000, 16'hBEEF, 2, 1, 16'hA5A5, 16'h1234, 0, 16'h0020, 16'hBEEF);
    vecs[2] = mk(0, 1, 0, 0, 16'h0000, 16'h0020, 16'h0000, 16'h0000, 3, 0, 16'hA5A5, 16'hBEEF, 0, 16'h0020, 16'hBEEF);
    vecs[3] = mk(1, 0, 0, 1, 16'h0030, 16'h0030, 16'h0000, 16'h2222, 4, 1, 16'h1111, 16'hBEEF, 0, 16'h0030, 16'h2222);
    vecs[4] = mk(1, 0, 1, 0, 16'h0040, 16'h0000, 16'h00FF, 16'h0000, 2, 1, 16'h1111, 16'hBEEF, 1, 16'h0040, 16'h00FF);
    vecs[5] = mk(0, 1, 1, 0, 16'h0050, 16'h0050, 16'h5A5A, 16'h0000, 4, 1, 16'h1111, 16'h5A5A, 0, 16'h0050, 16'h5A5A);
    vecs[6] = mk(0, 0, 1, 1, 16'h0060, 16'h0061, 16'h0101, 16'h0202, 3, 2, 16'h1111, 16'h5A5A, 0, 16'h0061, 16'h0202);
    vecs[7] = mk(0, 1, 0, 1, 16'h0000, 16'h0062, 16'h0000, 16'h0303, 2, 1, 16'h1111, 16'h5A5A, 1, 16'h0062, 16'h0303);

    repeat (3) @(posedge clk);
    @(negedge clk);
    Reset = 0;
    @(negedge clk);
    chk("reset_a_rdata", {ifa.rdata1, ifa.rdata2}, 32'h0);
    chk("reset_a_ctl", {27'h0, ifa.ready, ifa.busy, ifa.conflict, ifa.sram_re, ifa.sram_we}, 32'h0);
    chk("reset_a_sram", {ifa.sram_addr, ifa.sram_wdata}, 32'h0);
    chk("reset_b_all", {ifb.rdata1 | ifb.rdata2 | ifb.sram_addr | ifb.sram_wdata,
                        11'h0, ifb.ready, ifb.busy, ifb.conflict, ifb.sram_re, ifb.sram_we}, 32'h0);

    for (int i = 0; i < 8; i++) begin
      run_a(vecs[i], n, we_cnt, busy_bad, conf);
      chk($sformatf("v%0d_latency", i), n, vecs[i].n);
      chk($sformatf("v%0d_we_cycles", i), we_cnt, vecs[i].we);
      chk($sformatf("v%0d_busy", i), {31'h0, busy_bad}, 32'h0);
      chk($sformatf("v%0d_conflict", i), {31'h0, conf}, {31'h0, vecs[i].conf});
      @(negedge clk);
      chk($sformatf("v%0d_rdata", i), {ifa.rdata1, ifa.rdata2}, {vecs[i].rd1, vecs[i].rd2});
      chk($sformatf("v%0d_idle", i), {30'h0, ifa.ready, ifa.busy}, 32'h0);
      chk($sformatf("v%0d_mem", i), {16'h0, mem_a[vecs[i].maddr]}, {16'h0, vecs[i].mval});
    end

    // Held strobe is recaptured in IDLE the cycle after ready.
    ifa.MemR1 = 1; ifa.addr1 = 16'h0010;
    t1 = 0; t2 = 0;
    for (int c = 0; c <= 40; c++) begin
      if (ifa.ready) begin
        if (t1 == 0) t1 = c;
        else begin
          t2 = c;
          break;
        end
      end
      @(negedge clk);
    end
    ifa.MemR1 = 0;
    chk("b2b_first_ready", t1, 3);
    chk("b2b_second_ready", t2, 7);
    chk("b2b_rdata1", {16'h0, ifa.rdata1}, 32'h0000A5A5);
    @(negedge clk);

    // Reset during WAIT1: abort without ready, rdata cleared.
    ifa.MemR1 = 1; ifa.addr1 = 16'h0070;
    @(posedge clk);
    @(negedge clk);
    ifa.MemR1 = 0;
    chk("rst_acc1_re", {31'h0, ifa.sram_re}, 32'h1);
    @(negedge clk);
    chk("rst_wait1_busy", {30'h0, ifa.busy, ifa.ready}, 32'h2);
    Reset = 1;
    @(negedge clk);
    Reset = 0;
    chk("rst_mid_rdata", {ifa.rdata1, ifa.rdata2}, 32'h0);
    chk("rst_mid_ctl", {27'h0, ifa.ready, ifa.busy, ifa.conflict, ifa.sram_re, ifa.sram_we}, 32'h0);
    chk("rst_mid_addr", {16'h0, ifa.sram_addr}, 32'h0);
    @(negedge clk);
    chk("rst_no_ready", {31'h0, ifa.ready}, 32'h0);
    run_a(mk(1, 0, 0, 0, 16'h0070, 16'h0000, 16'h0000, 16'h0000, 3, 0, 16'h3C3C, 16'h0000, 0, 16'h0070, 16'h3C3C),
          n, we_cnt, busy_bad, conf);
    chk("post_rst_latency", n, 3);
    @(negedge clk);
    chk("post_rst_rdata", {ifa.rdata1, ifa.rdata2}, 32'h3C3C0000);

    // READ_LAT=3 dual read with strobes toggled while busy.
    ifb.MemR1 = 1; ifb.MemR2 = 1; ifb.addr1 = 16'h0010; ifb.addr2 = 16'h0011;
    @(posedge clk);
    @(negedge clk);
    n = 0; we_cnt = 0; busy_bad = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c <= 7) begin
        ifb.MemR1 = c[1]; ifb.MemW1 = c[0]; ifb.MemR2 = ~c[0]; ifb.MemW2 = c[2];
        ifb.addr1 = 16'(c); ifb.addr2 = 16'(c + 8); ifb.wdata1 = 16'hFFFF; ifb.wdata2 = 16'hEEEE;
      end else begin
        ifb.MemR1 = 0; ifb.MemW1 = 0; ifb.MemR2 = 0; ifb.MemW2 = 0;
      end
      if (ifb.sram_we) we_cnt++;
      if (!ifb.busy) busy_bad = 1;
      if (ifb.ready) begin
        n = c;
        break;
      end
      @(negedge clk);
    end
    chk("lat3_latency", n, 9);
    chk("lat3_no_write", we_cnt, 0);
    chk("lat3_busy", {31'h0, busy_bad}, 32'h0);
    @(negedge clk);
    rd1_b = ifb.rdata1;
    rd2_b = ifb.rdata2;
    chk("lat3_rdata", {rd1_b, rd2_b}, 32'hCAFE7777);
    chk("lat3_idle", {30'h0, ifb.busy, ifb.ready}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the control unit's dual memory strobes (MemR1/MemR2/MemW1/MemW2).
- Serializes port-1 and port-2 requests onto one single-port synchronous SRAM with fixed read latency.
- Returns read data per port and a one-cycle `ready` pulse on completion.
- Sits between control unit/datapath and instruction/data memory; control unit holds its state until `ready`.

Parameters:
DATA_W, 16, data width of both ports and SRAM
ADDR_W, 16, address width of both ports and SRAM
READ_LAT, 1, SRAM read latency in cycles; legal range 1..7

Ports:
clk  in  1  system clock
Reset  in  1  synchronous active-high reset
MemR1  in  1  port-1 read strobe
MemR2  in  1  port-2 read strobe
MemW1  in  1  port-1 write strobe
MemW2  in  1  port-2 write strobe
addr1  in  ADDR_W  port-1 address
addr2  in  ADDR_W  port-2 address
wdata1  in  DATA_W  port-1 write data
wdata2  in  DATA_W  port-2 write data
rdata1  out  DATA_W  port-1 read data, registered
rdata2  out  DATA_W  port-2 read data, registered
ready  out  1  one-cycle completion pulse
busy  out  1  high in every state except IDLE
conflict  out  1  pulses with `ready` if a port had R and W strobes together
sram_addr  out  ADDR_W  SRAM address
sram_wdata  out  DATA_W  SRAM write data
sram_re  out  1  SRAM read enable
sram_we  out  1  SRAM write enable
sram_rdata  in  DATA_W  SRAM read data; valid READ_LAT cycles after the sram_re cycle

Behaviour:
- Reset (sampled at the clk edge) forces state IDLE and clears all counters and captured requests.
- Outputs after reset: rdata1=0, rdata2=0, ready=0, busy=0, conflict=0, sram_*=0.
- Request capture:
  - Strobes are sampled only in IDLE.
  - Any strobe high at an edge in IDLE captures all strobes, addresses and write data into registers.
  - Strobes are ignored while busy=1.
- Per-port operation:
  - W and R both high on one port: treated as a write; that port's rdata is unchanged; conflict latched.
  - Only R high: read.
  - Neither high: port skipped.
- States: IDLE, ACC1, WAIT1, ACC2, WAIT2, DONE.
- Transitions:
  - IDLE -> ACC1 when a port-1 op is captured; else -> ACC2 when only port 2 is active.
  - ACC1: sram_addr=addr1_q.
    - Write: sram_we=1, sram_wdata=wdata1_q; next ACC2 if port 2 is active, else DONE.
    - Read: sram_re=1; next WAIT1.
  - WAIT1: lasts exactly READ_LAT cycles (3-bit down-counter). rdata1 loads sram_rdata on the last wait cycle's edge. Next ACC2 or DONE.
  - ACC2/WAIT2: identical behaviour for port 2. Next DONE.
  - DONE: ready=1 for exactly one cycle; conflict=latched value; next IDLE.
- Outside ACC states, sram_re, sram_we, sram_addr and sram_wdata are all 0.
- Latency, counted in cycles after the capture edge, with ready in the Nth cycle:
  - single write: N=2
  - dual write: N=3
  - single read: N=2+READ_LAT
  - dual read: N=3+2*READ_LAT
- Ordering: port 1 is always served before port 2.
  - A port-1 read and port-2 write to the same address: read returns the old data.
  - A port-1 write and port-2 read to the same address: read returns the new data.
- Back-to-back requests: a strobe held high through DONE is recaptured at the IDLE edge; the earliest new capture is 1 cycle after ready.
- Reset mid-operation: on the next edge go to IDLE.
  - An SRAM write in the current ACC cycle completes only if already driven at that edge.
  - rdata is cleared; no ready pulse.
- Read-data width equals DATA_W; no sign extension or truncation.

Test Plan:
- Reset, then dual read (MemR1, MemR2; addr1=0x0010 holding 0xA5A5, addr2=0x0011 holding 0x1234; READ_LAT=1) -> ready in 5th cycle, rdata1=0xA5A5, rdata2=0x1234, busy high for cycles 1-5.
- Single write (MemW2, addr2=0x0020, wdata2=0xBEEF), then single read of 0x0020 -> write: sram_we one cycle, ready in 2nd cycle; read: rdata2=0xBEEF, rdata1 unchanged.
- Same-address hazard at 0x0030 (old 0x1111): MemR1 and MemW2 with wdata2=0x2222 -> rdata1=0x1111, memory=0x2222.
- Conflict (MemR1 and MemW1, addr1=0x0040, wdata1=0x00FF) -> write performed, conflict=1 with ready, rdata1 unchanged.
- Strobes toggled during busy, plus READ_LAT=3 dual read -> extra strobes ignored; ready in 9th cycle.
- Reset asserted during WAIT1 -> IDLE next cycle, all outputs 0, no ready; new single read completes normally.
